// File: rtl/mul_fp52_pkg.sv
// Shared definitions for the mul_fp52 operand path.
// Contents: operand/result widths, the legal exponent ceiling, the packed
// operand-set struct carried from a requester to the multiplier, and two
// small helpers (exponent legality test, saturating counter increment).
package mul_fp52_pkg;

   localparam int FRAC_W  = 6;
   localparam int EXP_W   = 3;
   localparam int RES_W   = 18;
   localparam int EXP_MAX = 3;
   localparam int CNT_W   = 16;

   typedef struct packed {
      logic [FRAC_W-1:0] a_dat;
      logic [FRAC_W-1:0] b_dat;
      logic [FRAC_W-1:0] c_dat;
      logic [EXP_W-1:0]  a_exp;
      logic [EXP_W-1:0]  b_exp;
      logic [EXP_W-1:0]  c_exp;
   } opset_t;

   // An exponent field is illegal when it exceeds EXP_MAX (bit 2 set).
   function automatic logic exp_illegal(input opset_t op);
      return (op.a_exp > EXP_W'(EXP_MAX)) ||
             (op.b_exp > EXP_W'(EXP_MAX)) ||
             (op.c_exp > EXP_W'(EXP_MAX));
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   i_req  - request vector, one bit per requester
//   i_ptr  - index where the priority search starts
//   o_gnt  - one-hot grant (all zero when no request)
//   o_idx  - index of the granted requester (0 when none)
//   o_any  - at least one request present
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_sel;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_sum = '0;
      w_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Candidate index = (ptr + k) mod NREQ, computed one bit wider so
         // non-power-of-two NREQ wraps correctly.
         w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NREQ))
            w_sum = w_sum - (IDW+1)'(NREQ);
         w_sel = w_sum[IDW-1:0];
         if (!o_any && i_req[w_sel]) begin
            o_gnt[w_sel] = 1'b1;
            o_idx        = w_sel;
            o_any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_fp52_arb.sv
// Round-robin sharing of one mul_fp52 fused multiply-add unit among NREQ
// requesters. One operand set is accepted per cycle, registered into the
// issue stage that drives the multiplier, and its requester ID travels down
// a LAT-deep tag pipe so each result is returned with its owner's ID.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   req_valid / req_ready         - per-requester handshake
//   req_{a,b,c}_dat, req_*_exp    - packed per-requester operands
//   mul_{a,b,c}_dat, mul_*_exp    - registered operands to mul_fp52
//   mul_res                       - mul_fp52 result
//   rsp_valid, rsp_id, rsp_res    - result return (no backpressure)
//   exp_err                       - sticky illegal-exponent flag
//   issue_cnt                     - saturating count of accepted sets
module mul_fp52_arb
   import mul_fp52_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*FRAC_W-1:0] req_a_dat,
   input  logic [NREQ*FRAC_W-1:0] req_b_dat,
   input  logic [NREQ*FRAC_W-1:0] req_c_dat,
   input  logic [NREQ*EXP_W-1:0]  req_a_exp,
   input  logic [NREQ*EXP_W-1:0]  req_b_exp,
   input  logic [NREQ*EXP_W-1:0]  req_c_exp,
   output logic [FRAC_W-1:0]      mul_a_dat,
   output logic [FRAC_W-1:0]      mul_b_dat,
   output logic [FRAC_W-1:0]      mul_c_dat,
   output logic [EXP_W-1:0]       mul_a_exp,
   output logic [EXP_W-1:0]       mul_b_exp,
   output logic [EXP_W-1:0]       mul_c_exp,
   input  logic [RES_W-1:0]       mul_res,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [RES_W-1:0]       rsp_res,
   output logic                   exp_err,
   output logic [CNT_W-1:0]       issue_cnt
);

   opset_t                     w_ops [NREQ];
   opset_t                     w_sel_op;
   logic [NREQ-1:0]            w_gnt;
   logic [IDW-1:0]             w_idx;
   logic                       w_any;
   logic                       w_hs;

   logic [IDW-1:0]             r_ptr;
   opset_t                     r_op_p0;
   logic                       r_vld_p0;
   logic [IDW-1:0]             r_id_p0;
   logic [LAT-1:0]             r_tag_vld;
   logic [LAT-1:0][IDW-1:0]    r_tag_id;
   logic                       r_err;
   logic [CNT_W-1:0]           r_cnt;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_ops[i].a_dat = req_a_dat[FRAC_W*i +: FRAC_W];
         w_ops[i].b_dat = req_b_dat[FRAC_W*i +: FRAC_W];
         w_ops[i].c_dat = req_c_dat[FRAC_W*i +: FRAC_W];
         w_ops[i].a_exp = req_a_exp[EXP_W*i +: EXP_W];
         w_ops[i].b_exp = req_b_exp[EXP_W*i +: EXP_W];
         w_ops[i].c_exp = req_c_exp[EXP_W*i +: EXP_W];
      end
   end

   rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // The grant only reaches the requesters outside reset, so nothing can be
   // accepted while rst is held.
   assign req_ready = rst ? '0 : w_gnt;
   assign w_hs      = w_any & ~rst;
   assign w_sel_op  = w_ops[w_idx];

   // Stage p0: issue register feeding mul_fp52; operands hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= '0;
         r_op_p0  <= '0;
         r_vld_p0 <= 1'b0;
         r_id_p0  <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_vld_p0 <= w_hs;
         if (w_hs) begin
            r_ptr   <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            r_op_p0 <= w_sel_op;
            r_id_p0 <= w_idx;
            r_cnt   <= sat_inc(r_cnt);
            if (exp_illegal(w_sel_op))
               r_err <= 1'b1;
         end
      end
   end

   // Stages p1..pLAT: tag pipe tracking the mul_fp52 internal registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld[0] <= r_vld_p0;
         r_tag_id[0]  <= r_id_p0;
         for (int k = 1; k < LAT; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_id[k]  <= r_tag_id[k-1];
         end
      end
   end

   assign mul_a_dat = r_op_p0.a_dat;
   assign mul_b_dat = r_op_p0.b_dat;
   assign mul_c_dat = r_op_p0.c_dat;
   assign mul_a_exp = r_op_p0.a_exp;
   assign mul_b_exp = r_op_p0.b_exp;
   assign mul_c_exp = r_op_p0.c_exp;

   assign rsp_valid = r_tag_vld[LAT-1];
   assign rsp_id    = r_tag_id[LAT-1];
   assign rsp_res   = mul_res;
   assign exp_err   = r_err;
   assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_mul_fp52_arb.sv
// Bench for mul_fp52_arb with a behavioural 2-cycle stand-in for mul_fp52.
module tb_mul_fp52_arb;
   import mul_fp52_pkg::*;

   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int IDW  = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*FRAC_W-1:0] req_a_dat, req_b_dat, req_c_dat;
   logic [NREQ*EXP_W-1:0]  req_a_exp, req_b_exp, req_c_exp;
   logic [FRAC_W-1:0]      mul_a_dat, mul_b_dat, mul_c_dat;
   logic [EXP_W-1:0]       mul_a_exp, mul_b_exp, mul_c_exp;
   logic [RES_W-1:0]       mul_res = '0;
   logic                   rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [RES_W-1:0]       rsp_res;
   logic                   exp_err;
   logic [CNT_W-1:0]       issue_cnt;

   always #5 clk = ~clk;

   mul_fp52_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a_dat(req_a_dat), .req_b_dat(req_b_dat), .req_c_dat(req_c_dat),
      .req_a_exp(req_a_exp), .req_b_exp(req_b_exp), .req_c_exp(req_c_exp),
      .mul_a_dat(mul_a_dat), .mul_b_dat(mul_b_dat), .mul_c_dat(mul_c_dat),
      .mul_a_exp(mul_a_exp), .mul_b_exp(mul_b_exp), .mul_c_exp(mul_c_exp),
      .mul_res(mul_res),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res),
      .exp_err(exp_err), .issue_cnt(issue_cnt)
   );

   // Deterministic stand-in for the multiply-add arithmetic; only data
   // routing and alignment matter here.
   function automatic logic [17:0] fake_mul(input logic [5:0] a, b, c,
                                            input logic [2:0] ea, eb, ec);
      logic [17:0] p, q;
      p = ({12'd0, a} * {12'd0, b}) << ea[1:0];
      q = {12'd0, c} << (ec[1:0] + eb[1:0]);
      return (p + q) ^ {eb, 15'd0};
   endfunction

   // Unreset 2-stage pipeline, like the real unit.
   logic [17:0] r_s1 = '0;
   always @(posedge clk) begin
      r_s1    <= fake_mul(mul_a_dat, mul_b_dat, mul_c_dat, mul_a_exp, mul_b_exp, mul_c_exp);
      mul_res <= r_s1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [1:0]  id;
      logic [17:0] res;
   } exp_t;
   exp_t sb[$];

   int n_vec  = 0;
   int n_miss = 0;

   logic [5:0]  a [NREQ], b [NREQ], c [NREQ];
   logic [2:0]  ea [NREQ], eb [NREQ], ec [NREQ];
   int          m_ptr;
   logic [15:0] m_cnt;
   logic        m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic rnd(input int i);
      a[i]  = 6'($urandom);
      b[i]  = 6'($urandom);
      c[i]  = 6'($urandom);
      ea[i] = 3'($urandom_range(0, 3));
      eb[i] = 3'($urandom_range(0, 3));
      ec[i] = 3'($urandom_range(0, 3));
   endtask

   task automatic drive_bus();
      for (int i = 0; i < NREQ; i++) begin
         req_a_dat[6*i +: 6] = a[i];
         req_b_dat[6*i +: 6] = b[i];
         req_c_dat[6*i +: 6] = c[i];
         req_a_exp[3*i +: 3] = ea[i];
         req_b_exp[3*i +: 3] = eb[i];
         req_c_exp[3*i +: 3] = ec[i];
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_id", 32'(rsp_id), 32'(e.id));
         chk("rsp_res", 32'(rsp_res), 32'(e.res));
      end else begin
         chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
      chk("exp_err", 32'(exp_err), 32'(m_err));
   endtask

   // One clock cycle: apply valids, check ready against the model grant,
   // record the expected response, then check outputs after the edge.
   task automatic step(input logic [NREQ-1:0] v, output int g);
      int idx;
      logic [NREQ-1:0] exp_rdy;
      req_valid = v;
      drive_bus();
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (g < 0 && v[idx]) g = idx;
      end
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
         sb.push_back('{due: cyc + 1 + LAT, id: 2'(g),
                        res: fake_mul(a[g], b[g], c[g], ea[g], eb[g], ec[g])});
         m_ptr = (g + 1) % NREQ;
         if (ea[g] > 3 || eb[g] > 3 || ec[g] > 3) m_err = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
      if (g >= 0) rnd(g);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '1;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_cnt", 32'(issue_cnt), 32'd0);
      chk("rst_err", 32'(exp_err), 32'd0);
      chk("rst_mul_ops", 32'({mul_a_dat, mul_b_dat, mul_c_dat}), 32'd0);
      chk("rst_mul_exps", 32'({mul_a_exp, mul_b_exp, mul_c_exp}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      sb.delete();
      m_ptr = 0;
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) step('0, g);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst = 1'b1;
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) rnd(i);
      drive_bus();
      @(negedge clk);
      do_reset();

      // Single request, known operands: 0x20*0x20 = 0x400.
      a[0] = 6'h20; b[0] = 6'h20; c[0] = 6'h00;
      ea[0] = 3'd0; eb[0] = 3'd0; ec[0] = 3'd0;
      step(4'b0001, g);
      chk("t1_grant", 32'(g), 32'd0);
      chk("t1_model_res", 32'(fake_mul(6'h20, 6'h20, 6'h00, 3'd0, 3'd0, 3'd0)), 32'h400);
      idle(3);

      // All four requesters continuously valid from ptr 0.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(4'b1111, g);
         chk("rr_seq", 32'(g), 32'(k % 4));
      end
      idle(3);

      // Move ptr to 2, then contend between 1 and 3.
      step(4'b0010, g);
      chk("ptr_setup", 32'(g), 32'd1);
      step(4'b1010, g);
      chk("ptr2_first", 32'(g), 32'd3);
      step(4'b0010, g);
      chk("ptr2_second", 32'(g), 32'd1);
      idle(3);

      // Illegal exponent: flag set and sticky, response still returned.
      ea[2] = 3'd5;
      step(4'b0100, g);
      chk("experr_grant", 32'(g), 32'd2);
      idle(5);
      chk("experr_sticky", 32'(exp_err), 32'd1);

      // Reset with two responses in flight; they must vanish.
      step(4'b0001, g);
      step(4'b0010, g);
      do_reset();
      idle(4);
      step(4'b1010, g);
      chk("post_rst_grant", 32'(g), 32'd1);
      idle(3);

      // Saturation of issue_cnt with a single requester at full rate.
      do_reset();
      for (int k = 0; k < 65540; k++) begin
         step(4'b0001, g);
         if (k < 4) chk("single_full_rate", 32'(g), 32'd0);
      end
      idle(3);
      chk("cnt_saturated", 32'(issue_cnt), 32'h0000FFFF);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mul_fp52_arb.md
# mul_fp52_arb

Round-robin arbiter and sequencer that shares one `mul_fp52` fused multiply-add unit (fp(2,5) Booth multiplier plus addend, 2-cycle registered pipeline) between NREQ independent requesters. It accepts operand sets over per-requester valid/ready, issues at most one set per cycle into the multiplier through a registered issue stage, and tracks in-flight requester IDs so each 18-bit result returns to its originator. It sits between the MAC-array operand fetch logic and the `mul_fp52` instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- LAT, 2: `mul_fp52` latency, operands at its inputs to `res` valid.
- IDW, $clog2(NREQ): requester ID width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- req_valid  in  NREQ  per-requester operand set valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a_dat / req_b_dat / req_c_dat  in  NREQ*6 each  packed fraction operands, requester i at [6i+5:6i].
- req_a_exp / req_b_exp / req_c_exp  in  NREQ*3 each  packed exponents, requester i at [3i+2:3i], legal values 0..3.
- mul_a_dat / mul_b_dat / mul_c_dat  out  6 each  operands to `mul_fp52`.
- mul_a_exp / mul_b_exp / mul_c_exp  out  3 each  exponents to `mul_fp52`.
- mul_res  in  18  `mul_fp52` result.
- rsp_valid  out  1  result valid, no backpressure.
- rsp_id  out  IDW  requester that owns rsp_res.
- rsp_res  out  18  result, copy of mul_res.
- exp_err  out  1  sticky: a granted set had an exponent > 3.
- issue_cnt  out  16  saturating count of accepted sets.

## Operation
- Arbitration: round-robin over requesters with req_valid high, starting search at ptr; grant g sets req_ready[g]=1 combinationally when enable conditions hold (always, no stall source). Handshake = req_valid[g] & req_ready[g].
- req_ready may depend on req_valid; a requester must hold valid and data stable until accepted.
- On handshake: ptr <= (g+1) mod NREQ; issue register captures g's six fields; issue tag {v=1,id=g}. No handshake: issue tag v=0, operand registers hold previous value (no toggle).
- Tag pipe: LAT-stage shift register of {v,id} aligned with `mul_fp52` internal registers; output stage drives rsp_valid, rsp_id. rsp_res = mul_res unconditionally.
- exp_err set when any granted exponent field has bit 2 set; cleared only by rst. Operands still issued unchanged.
- issue_cnt increments per handshake, saturates at 16'hFFFF.
- Single requester valid continuously: granted every cycle, full throughput.

## Timing
- Reset values: req_ready 0 while rst high, ptr 0, all mul_* outputs 0, tag pipe v=0, rsp_valid 0, rsp_id 0, exp_err 0, issue_cnt 0.
- Handshake in cycle t -> mul_* driven in t+1 -> rsp_valid with matching rsp_id in t+1+LAT (t+3 default). Fixed, data-independent.
- One issue per cycle max; responses return in grant order.
- rst asserted mid-operation: all in-flight tags dropped, no rsp_valid for them even though `mul_fp52` (unreset) still produces data; first grant after deassertion goes to lowest valid index ≥ 0.
- ptr wrap NREQ-1 -> 0.
- Requester deasserting valid before grant: legal only if never seen ready; no state retained.

## Structure
- Package `mul_fp52_pkg`: FRAC_W=6, EXP_W=3, RES_W=18, EXP_MAX=3, operand-set struct {a_dat,b_dat,c_dat,a_exp,b_exp,c_exp}.
- Sub-module `rr_arb` (NREQ-wide, req vector + ptr in, one-hot grant + index out), reused elsewhere. Tag pipe and counters inline.

## Test plan
- Reset, req0 only, a=6'h20,b=6'h20,c=0, all exp 0 -> req_ready[0] same cycle, rsp_valid 3 cycles later, rsp_id=0, rsp_res=mul_res model value.
- All 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id same sequence 3 cycles delayed, back-to-back rsp_valid.
- req1 and req3 valid, ptr=2 -> grant 3 then 1; ptr=0 after.
- Grant with a_exp=3'd5 -> exp_err=1 and stays 1; rsp still returned.
- rst pulsed 1 cycle after two handshakes -> no rsp_valid in following 4 cycles, issue_cnt=0, ptr=0.
- Force issue_cnt to 16'hFFFE, two handshakes -> 16'hFFFF held.
